interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Arbitrates RES/NMI/IRQ/BRK requests and sequences the 7-cycle interrupt-entry micro-sequence
//  (dummy, push PCH, push PCL, push P, vector lo, vector hi, handoff) for the 6502C core.
//  Sits between the external interrupt pins and logicControl/instructionRegister.
//  Drives the stack-push enables, vector address and I-flag set; reports activeInt to the random logic.
// PARAMETERS
//  NMI_VEC   16'hFFFA  NMI vector low-byte address
//  RES_VEC   16'hFFFC  reset vector low-byte address
//  IRQ_VEC   16'hFFFE  IRQ/BRK vector low-byte address
// PORTS
//  phi1         in   1   core clock; all state updates on posedge phi1
//  rstAll       in   1   synchronous, active-high reset
//  haltAll      in   1   freeze: hold all state/outputs (NMI edge detect keeps running)
//  NMI_L        in   1   NMI pin, falling-edge sensitive
//  IRQ_L        in   1   IRQ pin, level sensitive, active low
//  RES_L        in   1   reset pin, level sensitive, active low
//  statusI      in   1   P register I flag (1 = IRQ masked)
//  brkOp        in   1   current opcode is BRK
//  insnBoundary in   1   core at T1 (instruction boundary); sequences may only start here
//  activeInt    out  3   0 NONE, 1 RST_i, 2 NMI_i, 3 IRQ_i, 4 BRK_i
//  seqStep      out  3   0 idle, 1..7 = entry cycle T0..T6
//  pushEn       out  1   write PCH/PCL/P to stack this cycle (steps 2-4; never for RES)
//  pushSel      out  2   0 PCH, 1 PCL, 2 P
//  pushB        out  1   B bit of pushed P (1 only for BRK)
//  vecAddr      out  16  vector fetch address (valid when vecRd=1)
//  vecRd        out  1   vector read this cycle (steps 5-6)
//  setI         out  1   one-cycle pulse at step 5: set I flag
//  intHandled   out  1   one-cycle pulse at step 7: sequence complete
//  busy         out  1   seqStep != 0
// BEHAVIOUR
//  Reset: state IDLE, seqStep=0, activeInt=0, all pulses/enables 0, vecAddr=0,
//    nmiPending=0, NMI_L history=1.
//  NMI detect: prev=1 & NMI_L=0 sets nmiPending. Cleared on step 5 of an NMI-vectored sequence.
//    An edge on that same cycle re-sets it (set wins).
//  Requests: resReq=~RES_L; irqReq=~IRQ_L & ~statusI (not latched).
//  Start: IDLE & insnBoundary & ~haltAll. Priority RES > NMI > IRQ > BRK.
//    Load activeInt, step=1 next cycle.
//  Steps: advance one per phi1 cycle 1->7.
//    2,3,4: pushEn=1 unless RES, pushSel=step-2.
//    5: vecRd, vecAddr=VEC, setI=1.
//    6: vecRd, vecAddr=VEC+1.
//    7: intHandled=1, activeInt->0, return to IDLE. 7 cycles total, no bubble before next start.
//  RES_L low mid-sequence: abort; next cycle restarts at step 1 as RST_i.
//    RES_L held low keeps restarting at step 1.
//  rstAll beats everything, including haltAll.
//  haltAll: no step advance and no new start; pulses are not repeated when the halt releases.
//  IRQ released mid-sequence: the sequence completes normally.
//  IRQ arriving during a sequence: ignored until IDLE.
// CONFIGURATION
//  NMI_HIJACK_EN defined: if nmiPending is set during steps 1-4 of an IRQ/BRK sequence,
//    steps 5/6 use NMI_VEC, activeInt becomes NMI_i, and nmiPending clears at step 5.
//    pushB is unchanged (BRK still pushes B=1).
//  NMI_HIJACK_EN undefined: the vector is fixed at start; the NMI is serviced at the next boundary.
// TESTING
//  RES_L=0 for 2 cycles then 1, insnBoundary=1 -> steps 1..7, pushEn never 1,
//    vecAddr FFFC/FFFD, intHandled at step 7.
//  IRQ_L=0, statusI=0, boundary -> pushEn at steps 2-4 (sel 0,1,2), pushB=0,
//    vecAddr FFFE/FFFF, setI at step 5.
//  IRQ_L=0, statusI=1 -> no start. Then NMI_L 1->0 -> NMI sequence, vecAddr FFFA,
//    nmiPending cleared at step 5.
//  brkOp=1 with NMI edge at step 3 -> with NMI_HIJACK_EN: vecAddr FFFA, pushB=1;
//    without: vecAddr FFFE, then NMI sequence at next boundary.
//  haltAll=1 for 3 cycles at step 4 -> seqStep holds 4, pushEn stays 1;
//    total sequence length becomes 10 cycles.
//  RES_L=0 at step 5 of IRQ -> next cycle step 1 with activeInt=1; rstAll=1 anytime -> all outputs 0.

Source files
------------

// File: rtl/interrupt_sequencer_if.sv
// Interrupt sequencer bus: the pin and core-status inputs, and the
// sequencing outputs consumed by logicControl/instructionRegister.
// The core side (or a testbench) uses the master modport. The sequencer
// uses the slave modport.
interface interrupt_sequencer_if;
  // Inputs to the sequencer
  logic        haltAll;
  logic        NMI_L;
  logic        IRQ_L;
  logic        RES_L;
  logic        statusI;
  logic        brkOp;
  logic        insnBoundary;

  // Outputs from the sequencer
  logic [2:0]  activeInt;
  logic [2:0]  seqStep;
  logic        pushEn;
  logic [1:0]  pushSel;
  logic        pushB;
  logic [15:0] vecAddr;
  logic        vecRd;
  logic        setI;
  logic        intHandled;
  logic        busy;

  modport master (
    output haltAll, NMI_L, IRQ_L, RES_L, statusI, brkOp, insnBoundary,
    input  activeInt, seqStep, pushEn, pushSel, pushB, vecAddr, vecRd,
           setI, intHandled, busy
  );

  modport slave (
    input  haltAll, NMI_L, IRQ_L, RES_L, statusI, brkOp, insnBoundary,
    output activeInt, seqStep, pushEn, pushSel, pushB, vecAddr, vecRd,
           setI, intHandled, busy
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: arbitrates RES/NMI/IRQ/BRK and walks the 7-cycle
// interrupt-entry sequence of the 6502C core:
//   T0 dummy, T1 push PCH, T2 push PCL, T3 push P, T4 vector lo,
//   T5 vector hi, T6 handoff.
// Optional build macro NMI_HIJACK_EN: an NMI that becomes pending during
// the push phase of an IRQ/BRK sequence takes over its vector fetch.
// Without the macro, the vector is fixed when the sequence starts.
module interrupt_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RES_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic                  phi1,
  input  logic                  rstAll,
  interrupt_sequencer_if.slave  bus
);

  // The state encoding doubles as the seqStep output (0 idle, 1..7 = T0..T6).
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DUMMY    = 3'd1,
    ST_PUSH_PCH = 3'd2,
    ST_PUSH_PCL = 3'd3,
    ST_PUSH_P   = 3'd4,
    ST_VEC_LO   = 3'd5,
    ST_VEC_HI   = 3'd6,
    ST_HANDOFF  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    INT_NONE = 3'd0,
    INT_RST  = 3'd1,
    INT_NMI  = 3'd2,
    INT_IRQ  = 3'd3,
    INT_BRK  = 3'd4
  } int_t;

  state_t state_q, state_d;
  int_t   act_q, act_d;
  // The BRK origin is kept separately so that a hijacked BRK still pushes B=1.
  logic   brk_q, brk_d;
  // Set on the first cycle spent in a step. It makes the setI and intHandled
  // pulses single-cycle even if a halt holds the step.
  logic   fresh_q, fresh_d;

  logic   nmi_pending;
  logic   nmi_prev;

  logic   res_req;
  logic   irq_req;
  logic   nmi_edge;
  logic   nmi_clear;
  logic   set_i;
  logic   int_handled;
  logic   push_en;
  logic   vec_rd;
  logic [15:0] vec_base;

  assign res_req  = ~bus.RES_L;
  assign irq_req  = ~bus.IRQ_L & ~bus.statusI;
  assign nmi_edge = nmi_prev & ~bus.NMI_L;

  assign set_i       = (state_q == ST_VEC_LO)  && fresh_q;
  assign int_handled = (state_q == ST_HANDOFF) && fresh_q;
  // The NMI is consumed when its vector fetch begins.
  assign nmi_clear   = set_i && (act_q == INT_NMI);

  // NMI falling-edge detector and pending latch. This keeps running through haltAll.
  always_ff @(posedge phi1) begin
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples pre-edge values, whatever order the simulator evaluates blocks in.
    if (rstAll) begin
      nmi_prev    <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_prev <= bus.NMI_L;
      if (nmi_edge) begin
        nmi_pending <= 1'b1;
      end else if (nmi_clear) begin
        nmi_pending <= 1'b0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge phi1) begin
    if (rstAll) begin
      state_q <= ST_IDLE;
      act_q   <= INT_NONE;
      brk_q   <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      brk_q   <= brk_d;
      fresh_q <= fresh_d;
    end
  end

  // Next-state logic: arbitration at the boundary, step advance, RES abort, optional NMI hijack.
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that leaves one
    // unassigned would infer a latch.
    state_d = state_q;
    act_d   = act_q;
    brk_d   = brk_q;
    fresh_d = 1'b0;

    if (!bus.haltAll) begin
      if (state_q == ST_IDLE) begin
        if (bus.insnBoundary) begin
          if (res_req) begin
            state_d = ST_DUMMY;
            act_d   = INT_RST;
            brk_d   = 1'b0;
            fresh_d = 1'b1;
          end else if (nmi_pending) begin
            state_d = ST_DUMMY;
            act_d   = INT_NMI;
            brk_d   = 1'b0;
            fresh_d = 1'b1;
          end else if (irq_req) begin
            state_d = ST_DUMMY;
            act_d   = INT_IRQ;
            brk_d   = 1'b0;
            fresh_d = 1'b1;
          end else if (bus.brkOp) begin
            state_d = ST_DUMMY;
            act_d   = INT_BRK;
            brk_d   = 1'b1;
            fresh_d = 1'b1;
          end
        end
      end else if (res_req) begin
        // Reset aborts any sequence in flight, including a reset sequence, and restarts at T0.
        state_d = ST_DUMMY;
        act_d   = INT_RST;
        brk_d   = 1'b0;
        fresh_d = 1'b1;
      end else if (state_q == ST_HANDOFF) begin
        state_d = ST_IDLE;
        act_d   = INT_NONE;
        brk_d   = 1'b0;
      end else begin
        state_d = state_t'(state_q + 3'd1);
        fresh_d = 1'b1;
`ifdef NMI_HIJACK_EN
        // A pending NMI seen before the vector fetch redirects an IRQ/BRK
        // entry to the NMI vector. The pushed B bit stays as it was.
        if (nmi_pending &&
            (state_q inside {ST_DUMMY, ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P}) &&
            (act_q inside {INT_IRQ, INT_BRK})) begin
          act_d = INT_NMI;
        end
`endif
      end
    end
  end

  // Output decode from the current step and interrupt type.
  always_comb begin
    push_en  = 1'b0;
    vec_rd   = 1'b0;
    vec_base = IRQ_VEC;

    push_en = (state_q inside {ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P}) &&
              (act_q != INT_RST);
    vec_rd  = (state_q inside {ST_VEC_LO, ST_VEC_HI});

    case (act_q)
      INT_RST: vec_base = RES_VEC;
      INT_NMI: vec_base = NMI_VEC;
      default: vec_base = IRQ_VEC;
    endcase

    bus.seqStep    = state_q;
    bus.activeInt  = act_q;
    bus.busy       = (state_q != ST_IDLE);
    bus.pushEn     = push_en;
    bus.pushSel    = push_en ? 2'(state_q - ST_PUSH_PCH) : 2'd0;
    bus.pushB      = push_en && brk_q;
    bus.vecRd      = vec_rd;
    bus.vecAddr    = vec_rd ? (vec_base + {15'd0, (state_q == ST_VEC_HI)}) : 16'd0;
    bus.setI       = set_i;
    bus.intHandled = int_handled;
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer. A directed sequence covers
// the documented scenarios. A randomized phase follows. A reference model
// (integer step counter plus interrupt-kind rules) predicts every output on
// every cycle.
module tb_interrupt_sequencer;

  logic phi1 = 1'b0;
  logic rstAll;

  interrupt_sequencer_if bus();

  interrupt_sequencer dut (
    .phi1   (phi1),
    .rstAll (rstAll),
    .bus    (bus)
  );

  always #5 phi1 = ~phi1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state. kind: 0 none, 1 RST, 2 NMI, 3 IRQ, 4 BRK.
  int m_step  = 0;
  int m_kind  = 0;
  bit m_brk   = 1'b0;
  bit m_first = 1'b0;
  bit m_pend  = 1'b0;
  bit m_prev  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int vec_of(input int kind);
    case (kind)
      1:       return 32'hFFFC;
      2:       return 32'hFFFA;
      default: return 32'hFFFE;
    endcase
  endfunction

  // Compare every output, and the pending-NMI flag, against the model.
  task automatic check_all();
    int e_push, e_sel, e_vrd, e_vec;
    e_push = (m_step >= 2 && m_step <= 4 && m_kind != 1) ? 1 : 0;
    e_sel  = (e_push != 0) ? m_step - 2 : 0;
    e_vrd  = (m_step == 5 || m_step == 6) ? 1 : 0;
    e_vec  = (e_vrd != 0) ? vec_of(m_kind) + (m_step - 5) : 0;
    check("seqStep",    32'(bus.seqStep),    32'(m_step));
    check("activeInt",  32'(bus.activeInt),  32'(m_kind));
    check("busy",       32'(bus.busy),       32'(m_step != 0));
    check("pushEn",     32'(bus.pushEn),     32'(e_push));
    check("pushSel",    32'(bus.pushSel),    32'(e_sel));
    check("pushB",      32'(bus.pushB),      32'(e_push != 0 && m_brk));
    check("vecRd",      32'(bus.vecRd),      32'(e_vrd));
    check("vecAddr",    32'(bus.vecAddr),    32'(e_vec));
    check("setI",       32'(bus.setI),       32'(m_step == 5 && m_first));
    check("intHandled", 32'(bus.intHandled), 32'(m_step == 7 && m_first));
    check("nmiPending", 32'(dut.nmi_pending), 32'(m_pend));
  endtask

  // Advance the model by one phi1 edge, using the inputs applied to the DUT.
  task automatic model_update();
    bit edge_now, clr, old_pend, res, irq;
    int pick;
    edge_now = m_prev && (bus.NMI_L == 1'b0);
    clr      = (m_step == 5) && m_first && (m_kind == 2);
    old_pend = m_pend;
    res      = (bus.RES_L == 1'b0);
    irq      = (bus.IRQ_L == 1'b0) && (bus.statusI == 1'b0);
    if (rstAll) begin
      m_step = 0; m_kind = 0; m_brk = 0; m_first = 0; m_pend = 0; m_prev = 1;
    end else begin
      m_prev = bus.NMI_L;
      if (edge_now)  m_pend = 1'b1;
      else if (clr)  m_pend = 1'b0;
      if (bus.haltAll) begin
        m_first = 1'b0;
      end else if (m_step == 0) begin
        m_first = 1'b0;
        pick = 0;
        if (bus.insnBoundary) begin
          if (res)               pick = 1;
          else if (old_pend)     pick = 2;
          else if (irq)          pick = 3;
          else if (bus.brkOp)    pick = 4;
        end
        if (pick != 0) begin
          m_step = 1; m_kind = pick; m_brk = (pick == 4); m_first = 1'b1;
        end
      end else if (res) begin
        m_step = 1; m_kind = 1; m_brk = 1'b0; m_first = 1'b1;
      end else if (m_step == 7) begin
        m_step = 0; m_kind = 0; m_brk = 1'b0; m_first = 1'b0;
      end else begin
`ifdef NMI_HIJACK_EN
        if (m_step <= 4 && (m_kind == 3 || m_kind == 4) && old_pend) m_kind = 2;
`endif
        m_step  = m_step + 1;
        m_first = 1'b1;
      end
    end
  endtask

  // One clock: predict, clock the DUT, sample on the falling edge, compare.
  task automatic tick();
    model_update();
    @(posedge phi1);
    @(negedge phi1);
    check_all();
  endtask

  // Tick until the model reports idle (bounded).
  task automatic run_to_idle();
    int guard;
    guard = 0;
    while (m_step != 0 && guard < 30) begin
      tick();
      guard++;
    end
    check("run_to_idle_bound", 32'(guard < 30), 32'd1);
  endtask

  task automatic idle_inputs();
    bus.haltAll      = 1'b0;
    bus.IRQ_L        = 1'b1;
    bus.RES_L        = 1'b1;
    bus.statusI      = 1'b1;
    bus.brkOp        = 1'b0;
    bus.insnBoundary = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;

    rstAll = 1'b1;
    bus.NMI_L = 1'b1;
    idle_inputs();
    tick();
    tick();
    rstAll = 1'b0;
    tick();
    check("reset_step", 32'(bus.seqStep), 32'd0);
    check("reset_vec",  32'(bus.vecAddr), 32'd0);

    // Reset request held low for two cycles, then released.
    bus.RES_L = 1'b0; bus.insnBoundary = 1'b1;
    tick();
    check("res_start_step", 32'(bus.seqStep), 32'd1);
    check("res_start_int",  32'(bus.activeInt), 32'd1);
    tick();
    check("res_hold_step", 32'(bus.seqStep), 32'd1);
    bus.RES_L = 1'b1; bus.insnBoundary = 1'b0;
    tick(); tick(); tick();
    check("res_no_push", 32'(bus.pushEn), 32'd0);
    tick();
    check("res_vec_lo", 32'(bus.vecAddr), 32'hFFFC);
    tick();
    check("res_vec_hi", 32'(bus.vecAddr), 32'hFFFD);
    tick();
    check("res_handled", 32'(bus.intHandled), 32'd1);
    run_to_idle();

    // IRQ entry. The IRQ is released right after the start.
    bus.IRQ_L = 1'b0; bus.statusI = 1'b0; bus.insnBoundary = 1'b1;
    tick();
    check("irq_int", 32'(bus.activeInt), 32'd3);
    bus.IRQ_L = 1'b1; bus.insnBoundary = 1'b0;
    tick();
    check("irq_sel0", 32'(bus.pushSel), 32'd0);
    check("irq_push", 32'(bus.pushEn), 32'd1);
    tick();
    check("irq_sel1", 32'(bus.pushSel), 32'd1);
    tick();
    check("irq_sel2", 32'(bus.pushSel), 32'd2);
    check("irq_pushB", 32'(bus.pushB), 32'd0);
    tick();
    check("irq_vec_lo", 32'(bus.vecAddr), 32'hFFFE);
    check("irq_setI", 32'(bus.setI), 32'd1);
    tick();
    check("irq_vec_hi", 32'(bus.vecAddr), 32'hFFFF);
    run_to_idle();

    // A masked IRQ starts nothing. An NMI edge then wins.
    bus.IRQ_L = 1'b0; bus.statusI = 1'b1; bus.insnBoundary = 1'b1;
    tick(); tick();
    check("masked_irq_idle", 32'(bus.seqStep), 32'd0);
    bus.NMI_L = 1'b0;
    tick();
    check("nmi_pending_set", 32'(dut.nmi_pending), 32'd1);
    tick();
    check("nmi_int", 32'(bus.activeInt), 32'd2);
    bus.NMI_L = 1'b1; bus.insnBoundary = 1'b0;
    tick(); tick(); tick(); tick();
    check("nmi_vec_lo", 32'(bus.vecAddr), 32'hFFFA);
    tick();
    check("nmi_pending_clr", 32'(dut.nmi_pending), 32'd0);
    run_to_idle();
    bus.IRQ_L = 1'b1;

    // BRK with an NMI edge arriving during step 3.
    bus.brkOp = 1'b1; bus.insnBoundary = 1'b1;
    tick();
    check("brk_int", 32'(bus.activeInt), 32'd4);
    bus.brkOp = 1'b0; bus.insnBoundary = 1'b0;
    tick(); tick();
    bus.NMI_L = 1'b0;
    tick();
    check("brk_pushB", 32'(bus.pushB), 32'd1);
    tick();
`ifdef NMI_HIJACK_EN
    check("brk_hijack_vec", 32'(bus.vecAddr), 32'hFFFA);
    check("brk_hijack_int", 32'(bus.activeInt), 32'd2);
    run_to_idle();
    bus.insnBoundary = 1'b1;
    tick();
    check("brk_no_followup", 32'(bus.seqStep), 32'd0);
`else
    check("brk_vec", 32'(bus.vecAddr), 32'hFFFE);
    run_to_idle();
    bus.insnBoundary = 1'b1;
    tick();
    check("brk_followup_nmi", 32'(bus.activeInt), 32'd2);
    bus.insnBoundary = 1'b0;
    run_to_idle();
`endif
    bus.NMI_L = 1'b1; bus.insnBoundary = 1'b0;
    tick();

    // Halt for three cycles at step 4 stretches the sequence to 10 cycles.
    bus.IRQ_L = 1'b0; bus.statusI = 1'b0; bus.insnBoundary = 1'b1;
    tick();
    bus.IRQ_L = 1'b1; bus.insnBoundary = 1'b0;
    busy_cycles = 1;
    tick(); tick(); tick();
    busy_cycles += 3;
    bus.haltAll = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      busy_cycles++;
      check("halt_step", 32'(bus.seqStep), 32'd4);
      check("halt_push", 32'(bus.pushEn), 32'd1);
    end
    bus.haltAll = 1'b0;
    for (int i = 0; i < 20 && m_step != 0; i++) begin
      tick();
      if (bus.busy) busy_cycles++;
    end
    check("halt_length", 32'(busy_cycles), 32'd10);

    // Reset request at step 5 of an IRQ sequence.
    bus.IRQ_L = 1'b0; bus.statusI = 1'b0; bus.insnBoundary = 1'b1;
    tick();
    bus.IRQ_L = 1'b1; bus.insnBoundary = 1'b0;
    tick(); tick(); tick(); tick();
    check("abort_at5", 32'(bus.seqStep), 32'd5);
    bus.RES_L = 1'b0;
    tick();
    check("abort_step", 32'(bus.seqStep), 32'd1);
    check("abort_int",  32'(bus.activeInt), 32'd1);
    bus.RES_L = 1'b1;
    run_to_idle();

    // rstAll mid-sequence beats haltAll.
    bus.brkOp = 1'b1; bus.insnBoundary = 1'b1;
    tick();
    bus.brkOp = 1'b0; bus.insnBoundary = 1'b0;
    tick(); tick();
    rstAll = 1'b1; bus.haltAll = 1'b1;
    tick();
    check("rst_step", 32'(bus.seqStep), 32'd0);
    check("rst_int",  32'(bus.activeInt), 32'd0);
    rstAll = 1'b0; bus.haltAll = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rstAll           = ($urandom_range(0, 149) == 0);
      bus.haltAll      = ($urandom_range(0, 6) == 0);
      bus.RES_L        = !($urandom_range(0, 39) == 0);
      bus.IRQ_L        = !($urandom_range(0, 3) == 0);
      bus.statusI      = $urandom_range(0, 1) == 1;
      bus.brkOp        = ($urandom_range(0, 9) == 0);
      bus.insnBoundary = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) bus.NMI_L = ~bus.NMI_L;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
